// File: rtl/ram_2port_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter: requester IDs and the
// read-return tag that follows each accepted read down the pipeline.
package ram_2port_arbiter_pkg;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e owner;
    } rd_tag_t;

    localparam int unsigned TAG_W = $bits(rd_tag_t);

endpackage

// File: rtl/ram_2port_arbiter_if.sv
// One requester's write and read channels; the arbiter connects through the slave
// modport and the requester through the master modport.
interface ram_2port_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic             Wr_Req;
    logic [AW-1:0]    Wr_Addr;
    logic [WIDTH-1:0] Wr_Data;
    logic             Wr_Gnt;
    logic             Rd_Req;
    logic [AW-1:0]    Rd_Addr;
    logic             Rd_Gnt;
    logic             Rd_DV;
    logic [WIDTH-1:0] Rd_Data;

    modport master (
        output Wr_Req, Wr_Addr, Wr_Data, Rd_Req, Rd_Addr,
        input  Wr_Gnt, Rd_Gnt, Rd_DV, Rd_Data
    );

    modport slave (
        input  Wr_Req, Wr_Addr, Wr_Data, Rd_Req, Rd_Addr,
        output Wr_Gnt, Rd_Gnt, Rd_DV, Rd_Data
    );

endinterface

// File: rtl/RAM_2Port.sv
// Simple dual-port RAM: registered read with a data-valid pulse, no reset on the
// storage or read path.
module RAM_2Port #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic                     i_Wr_Clk,
    input  logic [$clog2(DEPTH)-1:0] i_Wr_Addr,
    input  logic                     i_Wr_DV,
    input  logic [WIDTH-1:0]         i_Wr_Data,
    input  logic                     i_Rd_Clk,
    input  logic [$clog2(DEPTH)-1:0] i_Rd_Addr,
    input  logic                     i_Rd_En,
    output logic                     o_Rd_DV,
    output logic [WIDTH-1:0]         o_Rd_Data
);

    logic [WIDTH-1:0] r_Mem [DEPTH];

    always_ff @(posedge i_Wr_Clk) begin
        if (i_Wr_DV) begin
            r_Mem[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Rd_Clk) begin
        o_Rd_Data <= r_Mem[i_Rd_Addr];
        o_Rd_DV   <= i_Rd_En;
    end

endmodule

// File: rtl/ram_2port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers the last winner so the
// other requester wins the next contention.
module rr_arb2
    import ram_2port_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    req_id_e last_q, last_d;

    always_comb begin
        gnt_o  = '0;
        last_d = last_q;
        if (req_i[REQ_A] && (!req_i[REQ_B] || last_q == REQ_B)) begin
            gnt_o[REQ_A] = 1'b1;
            last_d       = REQ_A;
        end else if (req_i[REQ_B]) begin
            gnt_o[REQ_B] = 1'b1;
            last_d       = REQ_B;
        end
    end

    // Reset to B so A wins the first contention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ram_2port_arbiter.sv
// Shares one RAM_2Port between requesters A and B with independent round-robin
// write and read channels; read data is routed back by a two-stage owner tag.
module ram_2port_arbiter
    import ram_2port_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    ram_2port_arbiter_if.slave  A,
    ram_2port_arbiter_if.slave  B
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]       wr_gnt, rd_gnt;
    logic             wr_dv_q, wr_dv_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             rd_en_q, rd_en_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    rd_tag_t          tag1_q, tag1_d, tag2_q;
    logic             ram_dv;
    logic [WIDTH-1:0] ram_data;

    rr_arb2 u_wr_arb (
        .clk_i  (i_Clk),
        .rst_ni (i_Rst_L),
        .req_i  ({B.Wr_Req, A.Wr_Req}),
        .gnt_o  (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk_i  (i_Clk),
        .rst_ni (i_Rst_L),
        .req_i  ({B.Rd_Req, A.Rd_Req}),
        .gnt_o  (rd_gnt)
    );

    assign A.Wr_Gnt = wr_gnt[REQ_A];
    assign B.Wr_Gnt = wr_gnt[REQ_B];
    assign A.Rd_Gnt = rd_gnt[REQ_A];
    assign B.Rd_Gnt = rd_gnt[REQ_B];

    always_comb begin
        wr_dv_d      = |wr_gnt;
        wr_addr_d    = wr_gnt[REQ_B] ? B.Wr_Addr : A.Wr_Addr;
        wr_data_d    = wr_gnt[REQ_B] ? B.Wr_Data : A.Wr_Data;
        rd_en_d      = |rd_gnt;
        rd_addr_d    = rd_gnt[REQ_B] ? B.Rd_Addr : A.Rd_Addr;
        tag1_d.valid = |rd_gnt;
        tag1_d.owner = rd_gnt[REQ_B] ? REQ_B : REQ_A;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_dv_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            tag1_q    <= '0;
            tag2_q    <= '0;
        end else begin
            wr_dv_q   <= wr_dv_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            tag1_q    <= tag1_d;
            tag2_q    <= tag1_q;
        end
    end

    RAM_2Port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_Wr_Clk  (i_Clk),
        .i_Wr_Addr (wr_addr_q),
        .i_Wr_DV   (wr_dv_q),
        .i_Wr_Data (wr_data_q),
        .i_Rd_Clk  (i_Clk),
        .i_Rd_Addr (rd_addr_q),
        .i_Rd_En   (rd_en_q),
        .o_Rd_DV   (ram_dv),
        .o_Rd_Data (ram_data)
    );

    // The RAM is not reset, so the registered tag qualifies its valid and data.
    assign A.Rd_DV   = tag2_q.valid && (tag2_q.owner == REQ_A) && ram_dv;
    assign B.Rd_DV   = tag2_q.valid && (tag2_q.owner == REQ_B) && ram_dv;
    assign A.Rd_Data = A.Rd_DV ? ram_data : '0;
    assign B.Rd_Data = B.Rd_DV ? ram_data : '0;

endmodule

// File: tb/tb_ram_2port_arbiter.sv
// Directed-vector bench for ram_2port_arbiter (WIDTH=8, DEPTH=4).
module tb_ram_2port_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ram_2port_arbiter_if #(.WIDTH(8), .DEPTH(4)) a_if ();
    ram_2port_arbiter_if #(.WIDTH(8), .DEPTH(4)) b_if ();

    ram_2port_arbiter #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .A       (a_if),
        .B       (b_if)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of requests, check grants and read returns mid-cycle.
    task automatic step(input string name,
                        input logic aw, input logic [1:0] awa, input logic [7:0] awd,
                        input logic bw, input logic [1:0] bwa, input logic [7:0] bwd,
                        input logic ar, input logic [1:0] ara,
                        input logic br, input logic [1:0] bra,
                        input logic [3:0] eg,
                        input logic eadv, input logic [7:0] ead,
                        input logic ebdv, input logic [7:0] ebd);
        a_if.Wr_Req  = aw;
        a_if.Wr_Addr = awa;
        a_if.Wr_Data = awd;
        b_if.Wr_Req  = bw;
        b_if.Wr_Addr = bwa;
        b_if.Wr_Data = bwd;
        a_if.Rd_Req  = ar;
        a_if.Rd_Addr = ara;
        b_if.Rd_Req  = br;
        b_if.Rd_Addr = bra;
        @(negedge clk);
        chk({name, " A_Wr_Gnt"}, {31'd0, a_if.Wr_Gnt}, {31'd0, eg[3]});
        chk({name, " B_Wr_Gnt"}, {31'd0, b_if.Wr_Gnt}, {31'd0, eg[2]});
        chk({name, " A_Rd_Gnt"}, {31'd0, a_if.Rd_Gnt}, {31'd0, eg[1]});
        chk({name, " B_Rd_Gnt"}, {31'd0, b_if.Rd_Gnt}, {31'd0, eg[0]});
        chk({name, " A_Rd_DV"}, {31'd0, a_if.Rd_DV}, {31'd0, eadv});
        chk({name, " A_Rd_Data"}, {24'd0, a_if.Rd_Data}, {24'd0, ead});
        chk({name, " B_Rd_DV"}, {31'd0, b_if.Rd_DV}, {31'd0, ebdv});
        chk({name, " B_Rd_Data"}, {24'd0, b_if.Rd_Data}, {24'd0, ebd});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string name, input logic eadv, input logic [7:0] ead,
                        input logic ebdv, input logic [7:0] ebd);
        step(name, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0, 4'b0000,
             eadv, ead, ebdv, ebd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_if.Wr_Req = 0; a_if.Wr_Addr = '0; a_if.Wr_Data = '0;
        a_if.Rd_Req = 0; a_if.Rd_Addr = '0;
        b_if.Wr_Req = 0; b_if.Wr_Addr = '0; b_if.Wr_Data = '0;
        b_if.Rd_Req = 0; b_if.Rd_Addr = '0;
        @(posedge clk);
        #1;

        // Grants follow requests combinationally even while in reset
        step("rst_gnt", 1, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 2'd0, 1, 2'd0, 4'b1001, 0, 8'h00, 0, 8'h00);
        idle("rst_idle", 0, 8'h00, 0, 8'h00);
        rst_n = 1'b1;

        // 1: reset release, no requests
        idle("t1_c0", 0, 8'h00, 0, 8'h00);
        idle("t1_c1", 0, 8'h00, 0, 8'h00);

        // 3: write contention from fresh pointers, strict alternation A,B,A,B
        step("t3_c0", 1, 2'd1, 8'hAA, 1, 2'd2, 8'hBB, 0, 2'd0, 0, 2'd0, 4'b1000, 0, 8'h00, 0, 8'h00);
        step("t3_c1", 0, 2'd1, 8'hAA, 1, 2'd2, 8'hBB, 0, 2'd0, 0, 2'd0, 4'b0100, 0, 8'h00, 0, 8'h00);
        step("t3_c2", 1, 2'd1, 8'hAA, 1, 2'd2, 8'hBB, 0, 2'd0, 0, 2'd0, 4'b1000, 0, 8'h00, 0, 8'h00);
        step("t3_c3", 1, 2'd1, 8'hAA, 1, 2'd2, 8'hBB, 0, 2'd0, 0, 2'd0, 4'b0100, 0, 8'h00, 0, 8'h00);
        step("t3_c4", 1, 2'd1, 8'hAA, 1, 2'd2, 8'hBB, 0, 2'd0, 0, 2'd0, 4'b1000, 0, 8'h00, 0, 8'h00);
        step("t3_c5", 1, 2'd1, 8'hAA, 1, 2'd2, 8'hBB, 0, 2'd0, 0, 2'd0, 4'b0100, 0, 8'h00, 0, 8'h00);

        // 2: A fills the RAM, B reads it back-to-back
        step("t2_c0", 1, 2'd0, 8'h11, 0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0, 4'b1000, 0, 8'h00, 0, 8'h00);
        step("t2_c1", 1, 2'd1, 8'h22, 0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0, 4'b1000, 0, 8'h00, 0, 8'h00);
        step("t2_c2", 1, 2'd2, 8'h33, 0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0, 4'b1000, 0, 8'h00, 0, 8'h00);
        step("t2_c3", 1, 2'd3, 8'h44, 0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0, 4'b1000, 0, 8'h00, 0, 8'h00);
        step("t2_c4", 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 2'd0, 1, 2'd0, 4'b0001, 0, 8'h00, 0, 8'h00);
        step("t2_c5", 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 2'd0, 1, 2'd1, 4'b0001, 0, 8'h00, 0, 8'h00);
        step("t2_c6", 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 2'd0, 1, 2'd2, 4'b0001, 0, 8'h00, 1, 8'h11);
        step("t2_c7", 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 2'd0, 1, 2'd3, 4'b0001, 0, 8'h00, 1, 8'h22);
        idle("t2_c8", 0, 8'h00, 1, 8'h33);
        idle("t2_c9", 0, 8'h00, 1, 8'h44);
        idle("t2_c10", 0, 8'h00, 0, 8'h00);

        // 4: same-cycle write/read returns old data, next-cycle read returns new
        step("t4_c0", 1, 2'd1, 8'h54, 0, 2'd0, 8'h00, 0, 2'd0, 1, 2'd1, 4'b1001, 0, 8'h00, 0, 8'h00);
        step("t4_c1", 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd1, 0, 2'd0, 4'b0010, 0, 8'h00, 0, 8'h00);
        idle("t4_c2", 0, 8'h00, 1, 8'h22);
        idle("t4_c3", 1, 8'h54, 0, 8'h00);
        idle("t4_c4", 0, 8'h00, 0, 8'h00);

        // 5: read contention (A granted last, so B first), then alternating returns
        step("t5_c0", 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd0, 1, 2'd3, 4'b0001, 0, 8'h00, 0, 8'h00);
        step("t5_c1", 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd0, 0, 2'd0, 4'b0010, 0, 8'h00, 0, 8'h00);
        step("t5_c2", 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 2'd0, 1, 2'd3, 4'b0001, 0, 8'h00, 1, 8'h44);
        step("t5_c3", 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd0, 0, 2'd0, 4'b0010, 1, 8'h11, 0, 8'h00);
        idle("t5_c4", 0, 8'h00, 1, 8'h44);
        idle("t5_c5", 1, 8'h11, 0, 8'h00);
        idle("t5_c6", 0, 8'h00, 0, 8'h00);

        // 6: reset right after a read grant and a write grant drops both
        step("t6_p0", 1, 2'd0, 8'hEE, 0, 2'd0, 8'h00, 0, 2'd0, 1, 2'd2, 4'b1001, 0, 8'h00, 0, 8'h00);
        rst_n = 1'b0;
        idle("t6_rst0", 0, 8'h00, 0, 8'h00);
        idle("t6_rst1", 0, 8'h00, 0, 8'h00);
        rst_n = 1'b1;
        idle("t6_rel0", 0, 8'h00, 0, 8'h00);
        idle("t6_rel1", 0, 8'h00, 0, 8'h00);
        step("t6_r0", 1, 2'd2, 8'h5A, 1, 2'd3, 8'hA5, 1, 2'd0, 1, 2'd1, 4'b1010, 0, 8'h00, 0, 8'h00);
        step("t6_r1", 0, 2'd0, 8'h00, 1, 2'd3, 8'hA5, 0, 2'd0, 1, 2'd1, 4'b0101, 0, 8'h00, 0, 8'h00);
        idle("t6_r2", 1, 8'h11, 0, 8'h00);
        step("t6_r3", 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd2, 0, 2'd0, 4'b0010, 0, 8'h00, 1, 8'h54);
        step("t6_r4", 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 2'd0, 1, 2'd3, 4'b0001, 0, 8'h00, 0, 8'h00);
        idle("t6_r5", 1, 8'h5A, 0, 8'h00);
        idle("t6_r6", 0, 8'h00, 1, 8'hA5);
        idle("t6_r7", 0, 8'h00, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
